pending_encoder: RTL and testbench
==================================

# pending_encoder

Registered 32-to-5 request encoder: the inverse of the 5-to-32 one-hot decoder used for register/enable selection in the MIPS datapath. It latches one-hot or multi-hot request pulses into a sticky pending vector and presents the highest-priority pending index as a 5-bit code over a valid/ready handshake. The consumer acknowledges one index per transfer. Typical consumers are exception/interrupt cause logic and writeback-port arbitration.

## Interface
- `N_REQ`, default 32: number of request lines; legal values are 2..32.
- `IDX_W`, default `$clog2(N_REQ)` (= 5): width of the encoded index.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `req`  in  N_REQ: request pulses; bit i set for ≥1 cycle marks index i pending.
- `mask`  in  N_REQ: 1 = index eligible for selection; 0 = latched but not selected.
- `out_valid`  out  1: `out_idx` / `out_onehot` hold a pending, eligible index.
- `out_ready`  in  1: consumer accepts the presented index this cycle.
- `out_idx`  out  IDX_W: encoded index; bit i → value i.
- `out_onehot`  out  N_REQ: decoded form of `out_idx`; all zero when `out_valid`=0.
- `pending`  out  N_REQ: current sticky pending vector, for debug and status.

## Operation
- Acknowledge: `ack` = `out_valid & out_ready`. `ack_oh` = `out_onehot` if `ack`, else 0.
- Pending update on every edge: `pend_next = (pend & ~ack_oh) | req`.
  - Set wins: a request on the bit being acknowledged in the same cycle re-pends it.
- Candidate set: `cand = pend_next & mask`.
- Two-state FSM on `out_valid`:
  - IDLE (`out_valid`=0): if `cand != 0`, load the output register with `encode(cand)` and go to PRESENT. Otherwise stay.
  - PRESENT: while `!out_ready`, hold `out_idx` and `out_onehot` stable. Mask or req changes do not alter the presented value.
  - PRESENT on `ack`: if `cand != 0`, load the next selection and stay in PRESENT (back-to-back, no bubble). Otherwise go to IDLE and clear the outputs.
- Selection in fixed-priority mode: the lowest set index of `cand` wins.
- An index that is masked after being presented remains valid until acknowledged.
- A masked pending bit stays latched indefinitely. It becomes selectable the cycle after it is unmasked.
- Reset mid-operation: all state is cleared immediately (asynchronously). In-flight pending requests are lost, with no acknowledge.
- Reset values:
  - `out_valid`=0, `out_idx`=0, `out_onehot`=0, `pending`=0.
  - Round-robin pointer (if compiled in) = 0.

## Timing
- Request to valid: `req[i]` sampled at edge N → `out_valid`=1 with `out_idx`=i after edge N. This is 1 cycle latency when idle.
- Acknowledge to next: `ack` at edge M → the next index is presented after edge M. This gives 1 transfer per cycle sustained.
- `pending` reflects `pend` after the edge. The acknowledged bit clears at the `ack` edge.
- No combinational path from `out_ready`, `req` or `mask` to any output; all outputs are registered.

## Configuration
- `PENDING_ENCODER_RR_EN` defined: rotating priority.
  - Adds register `rr_ptr[IDX_W-1:0]`, set to `out_idx+1` (mod N_REQ) on each `ack`.
  - Selection is the first set bit of `cand` at or above `rr_ptr`, wrapping to 0.
  - With all 32 bits pending, successive grants are 0,1,2,…,31,0.
- `PENDING_ENCODER_RR_EN` undefined: fixed lowest-index priority. No pointer register exists.

## Structure
- Package `pending_encoder_pkg`:
  - `localparam N_REQ_MAX = 32`.
  - `typedef logic [4:0] req_idx_t`.
  - Function `idx_to_onehot`, shared with the decoder side.
- Sub-module `prio_enc32`: purely combinational first-set-bit encoder.
  - Inputs: `vec`, `start`. Outputs: `found`, `idx`.
  - Built as four 8-bit stages plus a 2-bit group select, mirroring the decoder's 2x4/3x8 split.
  - `start` is tied to 0 when round robin is compiled out.

## Test plan
- Reset: hold `reset_n`=0 with `req`=32'hFFFFFFFF → all outputs 0. Release → `out_valid`=1, `out_idx`=0 one cycle later.
- Multi-hot drain: one-cycle `req`=32'h8000_0011, `mask`=all ones, `out_ready`=1 → `out_idx`=0, 4, 31 on three consecutive cycles, then `out_valid`=0 and `pending`=0.
- Backpressure: `req`=bit 7, `out_ready`=0 for 5 cycles, then `req`=bit 2 → `out_idx` stays 7 until `ack`, then 2 is presented next.
- Set wins over clear: `ack` of index 3 while `req[3]`=1 in the same cycle → `pending[3]`=1 and `out_idx`=3 is presented again.
- Mask: `req`=bit 5 with `mask[5]`=0 → `out_valid`=0 and `pending[5]`=1. Set `mask[5]`=1 → `out_idx`=5 one cycle later.
- Round robin (macro defined): `req`=32'h0000_0009 held, `out_ready`=1 → grants alternate 0,3,0,3. Macro undefined → grants are 0,0,0.

Source files
------------

// File: rtl/pending_encoder_pkg.sv
// Shared types and helpers for the pending request encoder.
// Contents:
//   N_REQ_MAX     - widest supported request vector (32)
//   req_idx_t     - 5-bit encoded request index
//   state_e       - output FSM states
//   idx_to_onehot - 5-to-32 decode, shared with the decoder side
package pending_encoder_pkg;

    localparam int unsigned N_REQ_MAX = 32;

    typedef logic [4:0] req_idx_t;

    typedef enum logic [0:0] {
        StIdle,
        StPresent
    } state_e;

    function automatic logic [N_REQ_MAX-1:0] idx_to_onehot(req_idx_t idx);
        logic [N_REQ_MAX-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/pending_encoder_if.sv
// Request/grant bundle between a request source/consumer and pending_encoder.
// Signals:
//   req        - request pulses, one bit per index
//   mask       - per-index selection enable
//   out_valid  - presented index is valid
//   out_ready  - consumer accepts the presented index
//   out_idx    - encoded index
//   out_onehot - decoded form of out_idx (zero when not valid)
//   pending    - sticky pending vector (status)
// Modports: slave = encoder side, master = source/consumer side.
interface pending_encoder_if #(
    parameter int unsigned N_REQ = 32,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) ();

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] mask;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic [N_REQ-1:0] out_onehot;
    logic [N_REQ-1:0] pending;

    modport slave (
        input  req,
        input  mask,
        input  out_ready,
        output out_valid,
        output out_idx,
        output out_onehot,
        output pending
    );

    modport master (
        output req,
        output mask,
        output out_ready,
        input  out_valid,
        input  out_idx,
        input  out_onehot,
        input  pending
    );

endinterface

// File: rtl/prio_enc32.sv
// Combinational first-set-bit encoder over 32 bits with a rotating start point.
// Ports:
//   vec   - candidate vector
//   start - search begins at this index and wraps to 0
//   found - vec has at least one bit set
//   idx   - index of the first set bit at/after start (wrapping)
// Built from four 8-bit stages and a 2-bit group select.
module prio_enc32
    import pending_encoder_pkg::*;
(
    input  logic [N_REQ_MAX-1:0] vec,
    input  req_idx_t             start,
    output logic                 found,
    output req_idx_t             idx
);

    // Returns {found, idx} for the lowest set bit of v.
    function automatic logic [5:0] first_set(logic [N_REQ_MAX-1:0] v);
        logic [3:0] grp_found;
        logic [2:0] grp_idx [4];
        logic [1:0] sel;
        for (int g = 0; g < 4; g++) begin
            grp_found[g] = |v[g*8 +: 8];
            grp_idx[g]   = 3'd0;
            for (int b = 7; b >= 0; b--) begin
                if (v[g*8 + b]) grp_idx[g] = 3'(b);
            end
        end
        if (grp_found[0])      sel = 2'd0;
        else if (grp_found[1]) sel = 2'd1;
        else if (grp_found[2]) sel = 2'd2;
        else                   sel = 2'd3;
        return {|grp_found, sel, grp_idx[sel]};
    endfunction

    logic [N_REQ_MAX-1:0] ge_mask;
    logic [5:0]           hi_res;
    logic [5:0]           lo_res;

    // Search bits at/above start first; fall back to the full vector to wrap.
    always_comb begin
        ge_mask = {N_REQ_MAX{1'b1}} << start;
        hi_res  = first_set(vec & ge_mask);
        lo_res  = first_set(vec);
        found   = lo_res[5];
        idx     = hi_res[5] ? hi_res[4:0] : lo_res[4:0];
    end

endmodule

// File: rtl/pending_encoder.sv
// Registered N-to-log2(N) request encoder with sticky pending bits.
// Requests are latched into a pending vector; the highest-priority pending,
// eligible index is presented over a valid/ready handshake, one per transfer.
// Ports:
//   clk     - clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - pending_encoder_if slave (req, mask, out_ready in;
//             out_valid, out_idx, out_onehot, pending out)
// Configuration:
//   PENDING_ENCODER_RR_EN defined   - rotating priority via rr_ptr
//   PENDING_ENCODER_RR_EN undefined - fixed lowest-index priority
module pending_encoder
    import pending_encoder_pkg::*;
#(
    parameter int unsigned N_REQ = 32,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input logic             clk,
    input logic             reset_n,
    pending_encoder_if.slave bus
);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_REQ-1:0]     oh_q, oh_d;
    logic [N_REQ-1:0]     pend_q, pend_d;

    logic                 ack;
    logic [N_REQ-1:0]     ack_oh;
    logic [N_REQ-1:0]     cand;
    logic [N_REQ_MAX-1:0] vec32;
    logic [N_REQ_MAX-1:0] sel_oh32;
    req_idx_t             start;
    logic                 enc_found;
    req_idx_t             enc_idx;

    always_comb begin
        ack    = (state_q == StPresent) & bus.out_ready;
        ack_oh = ack ? oh_q : '0;
        // Set wins: a request on the bit being acknowledged re-pends it.
        pend_d = (pend_q & ~ack_oh) | bus.req;
        cand   = pend_d & bus.mask;
        vec32  = '0;
        vec32[N_REQ-1:0] = cand;
    end

`ifdef PENDING_ENCODER_RR_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    // The pointer advances on the ack edge, and the selection made on that same
    // edge must already use the advanced value to rotate without a bubble.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (ack) begin
            rr_ptr_d = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        end
        start = '0;
        start[IDX_W-1:0] = rr_ptr_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rr_ptr_q <= '0;
        else          rr_ptr_q <= rr_ptr_d;
    end
`else
    assign start = '0;
`endif

    prio_enc32 u_prio_enc32 (
        .vec   (vec32),
        .start (start),
        .found (enc_found),
        .idx   (enc_idx)
    );

    assign sel_oh32 = idx_to_onehot(enc_idx);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        oh_d    = oh_q;
        unique case (state_q)
            StIdle: begin
                if (enc_found) begin
                    state_d = StPresent;
                    idx_d   = enc_idx[IDX_W-1:0];
                    oh_d    = sel_oh32[N_REQ-1:0];
                end
            end
            StPresent: begin
                // Without ack the presented index is frozen regardless of req/mask.
                if (ack) begin
                    if (enc_found) begin
                        idx_d = enc_idx[IDX_W-1:0];
                        oh_d  = sel_oh32[N_REQ-1:0];
                    end else begin
                        state_d = StIdle;
                        idx_d   = '0;
                        oh_d    = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
                oh_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            oh_q    <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.out_valid  = (state_q == StPresent);
    assign bus.out_idx    = idx_q;
    assign bus.out_onehot = oh_q;
    assign bus.pending    = pend_q;

endmodule

// File: tb/tb_pending_encoder.sv
// Self-checking bench for pending_encoder: directed stimulus pushes expected
// grant indices into a queue; a monitor pops and compares on every accepted
// transfer. Status checks (valid, pending, stability) are made inline.
module tb_pending_encoder;

    logic clk;
    logic reset_n;

    int unsigned n_cmp;
    int unsigned n_err;
    int unsigned exp_q[$];

    pending_encoder_if bus ();

    pending_encoder dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one pop per accepted transfer.
    always @(negedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_grant", 32'(bus.out_idx), 32'hFFFF_FFFF);
            end else begin
                automatic int unsigned e = exp_q.pop_front();
                automatic logic [31:0] eoh = 32'd1 << e;
                chk("grant_idx", 32'(bus.out_idx), e);
                chk("grant_onehot", bus.out_onehot, eoh);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n       = 1'b0;
        bus.req       = 32'hFFFF_FFFF;
        bus.mask      = 32'hFFFF_FFFF;
        bus.out_ready = 1'b0;

        // Reset held with all requests asserted.
        repeat (3) step();
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_idx", 32'(bus.out_idx), 32'd0);
        chk("rst_onehot", bus.out_onehot, 32'd0);
        chk("rst_pending", bus.pending, 32'd0);

        // Release: requests sampled on the first edge.
        reset_n = 1'b1;
        step();
        bus.req = '0;
        chk("rel_valid", 32'(bus.out_valid), 32'd1);
        chk("rel_idx", 32'(bus.out_idx), 32'd0);
        chk("rel_pending", bus.pending, 32'hFFFF_FFFF);
        for (int i = 0; i < 32; i++) exp_q.push_back(i);
        bus.out_ready = 1'b1;
        repeat (32) step();
        chk("full_drain_valid", 32'(bus.out_valid), 32'd0);
        chk("full_drain_pending", bus.pending, 32'd0);

        // Multi-hot drain, ready held high.
        exp_q.push_back(0);
        exp_q.push_back(4);
        exp_q.push_back(31);
        bus.req = 32'h8000_0011;
        step();
        bus.req = '0;
        chk("mh_first_idx", 32'(bus.out_idx), 32'd0);
        chk("mh_first_valid", 32'(bus.out_valid), 32'd1);
        repeat (3) step();
        chk("mh_valid", 32'(bus.out_valid), 32'd0);
        chk("mh_pending", bus.pending, 32'd0);

        // Backpressure.
        bus.out_ready = 1'b0;
        bus.req = 32'h0000_0080;
        step();
        bus.req = '0;
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold_idx", 32'(bus.out_idx), 32'd7);
            step();
        end
        bus.req = 32'h0000_0004;
        step();
        bus.req = '0;
        chk("bp_hold_idx2", 32'(bus.out_idx), 32'd7);
        chk("bp_hold_oh", bus.out_onehot, 32'h0000_0080);
        chk("bp_pending", bus.pending, 32'h0000_0084);
        exp_q.push_back(7);
        exp_q.push_back(2);
        bus.out_ready = 1'b1;
        step();
        chk("bp_next_idx", 32'(bus.out_idx), 32'd2);
        step();
        bus.out_ready = 1'b0;
        chk("bp_done_valid", 32'(bus.out_valid), 32'd0);

        // Set wins over clear.
        bus.req = 32'h0000_0008;
        step();
        chk("sw_first_idx", 32'(bus.out_idx), 32'd3);
        exp_q.push_back(3);
        bus.out_ready = 1'b1;
        step();
        bus.req = '0;
        bus.out_ready = 1'b0;
        chk("sw_pending", bus.pending, 32'h0000_0008);
        chk("sw_valid", 32'(bus.out_valid), 32'd1);
        chk("sw_idx", 32'(bus.out_idx), 32'd3);
        exp_q.push_back(3);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("sw_done_valid", 32'(bus.out_valid), 32'd0);
        chk("sw_done_pending", bus.pending, 32'd0);

        // Mask: latched but not selected until unmasked.
        bus.mask = ~32'h0000_0020;
        bus.req  = 32'h0000_0020;
        step();
        bus.req = '0;
        chk("mask_valid", 32'(bus.out_valid), 32'd0);
        chk("mask_pending", bus.pending, 32'h0000_0020);
        step();
        chk("mask_valid2", 32'(bus.out_valid), 32'd0);
        bus.mask = 32'hFFFF_FFFF;
        step();
        chk("unmask_valid", 32'(bus.out_valid), 32'd1);
        chk("unmask_idx", 32'(bus.out_idx), 32'd5);
        // Masking after presentation does not withdraw it.
        bus.mask = '0;
        step();
        chk("remask_valid", 32'(bus.out_valid), 32'd1);
        chk("remask_idx", 32'(bus.out_idx), 32'd5);
        exp_q.push_back(5);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.mask = 32'hFFFF_FFFF;
        chk("remask_done_valid", 32'(bus.out_valid), 32'd0);

        // Held requests on bits 0 and 3.
        bus.req = 32'h0000_0009;
        step();
        chk("rr_first_idx", 32'(bus.out_idx), 32'd0);
`ifdef PENDING_ENCODER_RR_EN
        exp_q.push_back(0);
        exp_q.push_back(3);
        exp_q.push_back(0);
        exp_q.push_back(3);
`else
        for (int i = 0; i < 4; i++) exp_q.push_back(0);
`endif
        bus.out_ready = 1'b1;
        repeat (4) step();
        bus.req = '0;
        exp_q.push_back(0);
        exp_q.push_back(3);
        repeat (2) step();
        bus.out_ready = 1'b0;
        chk("rr_done_valid", 32'(bus.out_valid), 32'd0);
        chk("rr_done_pending", bus.pending, 32'd0);

        // Reset mid-operation clears state immediately.
        bus.req = 32'h0000_0202;
        step();
        bus.req = '0;
        chk("mid_valid", 32'(bus.out_valid), 32'd1);
        chk("mid_idx", 32'(bus.out_idx), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_idx", 32'(bus.out_idx), 32'd0);
        chk("mid_rst_pending", bus.pending, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
